// File: rtl/traffic_pkg.sv
// Shared types for the intersection controller: phase encoding, lamp codes
// and the state-to-lamp decode used by traffic_ctrl.
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_MAIN_G = 3'd0,
        ST_MAIN_Y = 3'd1,
        ST_RED1   = 3'd2,
        ST_SIDE_G = 3'd3,
        ST_SIDE_Y = 3'd4,
        ST_WALK   = 3'd5,
        ST_RED2   = 3'd6
    } state_t;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    typedef struct packed {
        logic [2:0] main_st;
        logic [2:0] side_st;
        logic       walk;
    } lamps_t;

    // Every street shows red unless the phase explicitly gives it green or yellow.
    function automatic lamps_t decode_lamps(input state_t s);
        lamps_t l;
        l.main_st = LAMP_R;
        l.side_st = LAMP_R;
        l.walk    = 1'b0;
        case (s)
            ST_MAIN_G: l.main_st = LAMP_G;
            ST_MAIN_Y: l.main_st = LAMP_Y;
            ST_SIDE_G: l.side_st = LAMP_G;
            ST_SIDE_Y: l.side_st = LAMP_Y;
            ST_WALK:   l.walk    = 1'b1;
            default:   ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_ctrl_tick_gen.sv
// Tick prescaler: free-running 0..TICK_DIV-1 counter producing a one-cycle
// tick on the last count; clear restarts the period.
module tick_gen #(
    parameter int TICK_DIV = 100
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;
    logic          at_last;

    assign at_last = (count == LAST);
    // NOTE: clear masks the tick so a reload never sees a tick in the same cycle.
    assign tick    = at_last && !clear;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || at_last) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/traffic_ctrl.sv
// Intersection sequencer wrapped around an external countdown timer: steps the
// phase FSM on timer expiry, reloads the timer and decodes the lamps.
module traffic_ctrl
    import traffic_pkg::*;
#(
    parameter int         TICK_DIV = 100,
    parameter logic [8:0] GREEN_T  = 9'd20,
    parameter logic [8:0] YELLOW_T = 9'd4,
    parameter logic [8:0] ALLRED_T = 9'd2,
    parameter logic [8:0] SIDE_T   = 9'd12,
    parameter logic [8:0] WALK_T   = 9'd15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       timer_expired,
    input  logic       walk_req,
    input  logic       side_sensor,
    output logic       count_en,
    output logic       load,
    output logic [8:0] load_value,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk_light
);

    state_t state;
    logic   started;
    logic   walk_pend;
    logic   fire;
    lamps_t lamps;

    // An expiry coincident with a reload is stale: the timer has not taken the new value yet.
    assign fire = timer_expired && !load;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock (clock),
        .reset (reset),
        .clear (load),
        .tick  (count_en)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_MAIN_G;
            started    <= 1'b0;
            walk_pend  <= 1'b0;
            load       <= 1'b0;
            load_value <= GREEN_T;
        end else begin
            started <= 1'b1;
            load    <= fire || !started;
            // NOTE: later non-blocking assignments win, so the WALK entry below overrides this update.
            walk_pend <= walk_pend || walk_req;
            if (!started) begin
                load_value <= GREEN_T;
            end
            if (fire) begin
                case (state)
                    ST_MAIN_G: begin
                        if (side_sensor || walk_pend || walk_req) begin
                            state      <= ST_MAIN_Y;
                            load_value <= YELLOW_T;
                        end else begin
                            load_value <= GREEN_T;
                        end
                    end
                    ST_MAIN_Y: begin
                        state      <= ST_RED1;
                        load_value <= ALLRED_T;
                    end
                    ST_RED1: begin
                        if (walk_pend) begin
                            state      <= ST_WALK;
                            load_value <= WALK_T;
                            walk_pend  <= walk_req;
                        end else begin
                            state      <= ST_SIDE_G;
                            load_value <= SIDE_T;
                        end
                    end
                    ST_SIDE_G: begin
                        state      <= ST_SIDE_Y;
                        load_value <= YELLOW_T;
                    end
                    ST_SIDE_Y, ST_WALK: begin
                        state      <= ST_RED2;
                        load_value <= ALLRED_T;
                    end
                    ST_RED2: begin
                        state      <= ST_MAIN_G;
                        load_value <= GREEN_T;
                    end
                    default: begin
                        state      <= ST_MAIN_G;
                        load_value <= GREEN_T;
                    end
                endcase
            end
        end
    end

    assign lamps      = decode_lamps(state);
    assign main_light = lamps.main_st;
    assign side_light = lamps.side_st;
    assign walk_light = lamps.walk;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Randomized bench for traffic_ctrl: a phase-level reference model feeds a
// scoreboard queue that an independent monitor drains on every load pulse.
module tb_traffic_ctrl;

    localparam int TD = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       timer_expired = 1'b0;
    logic       walk_req = 1'b0;
    logic       side_sensor = 1'b0;
    logic       count_en;
    logic       load;
    logic [8:0] load_value;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk_light;

    traffic_ctrl #(.TICK_DIV(TD)) dut (
        .clock         (clock),
        .reset         (reset),
        .timer_expired (timer_expired),
        .walk_req      (walk_req),
        .side_sensor   (side_sensor),
        .count_en      (count_en),
        .load          (load),
        .load_value    (load_value),
        .main_light    (main_light),
        .side_light    (side_light),
        .walk_light    (walk_light)
    );

    always #5 clock = ~clock;

    typedef enum {P_MAIN_G, P_MAIN_Y, P_RED1, P_SIDE_G, P_SIDE_Y, P_WALK, P_RED2} phase_e;

    typedef struct {
        phase_e     ph;
        logic [2:0] m;
        logic [2:0] s;
        logic       w;
        logic [8:0] d;
    } exp_t;

    exp_t   sb_q[$];
    int     n_checks = 0;
    int     n_pass   = 0;

    phase_e m_phase;
    bit     m_pend;
    bit     m_load_now;
    bit     m_fresh;
    int     m_since;

    function automatic exp_t expect_for(input phase_e p);
        exp_t e;
        e.ph = p;
        case (p)
            P_MAIN_G: begin e.m = 3'b001; e.s = 3'b100; e.w = 1'b0; e.d = 9'd20; end
            P_MAIN_Y: begin e.m = 3'b010; e.s = 3'b100; e.w = 1'b0; e.d = 9'd4;  end
            P_RED1:   begin e.m = 3'b100; e.s = 3'b100; e.w = 1'b0; e.d = 9'd2;  end
            P_SIDE_G: begin e.m = 3'b100; e.s = 3'b001; e.w = 1'b0; e.d = 9'd12; end
            P_SIDE_Y: begin e.m = 3'b100; e.s = 3'b010; e.w = 1'b0; e.d = 9'd4;  end
            P_WALK:   begin e.m = 3'b100; e.s = 3'b100; e.w = 1'b1; e.d = 9'd15; end
            default:  begin e.m = 3'b100; e.s = 3'b100; e.w = 1'b0; e.d = 9'd2;  end
        endcase
        return e;
    endfunction

    function automatic phase_e next_of(input phase_e p, input bit main_demand, input bit pend);
        case (p)
            P_MAIN_G: return main_demand ? P_MAIN_Y : P_MAIN_G;
            P_MAIN_Y: return P_RED1;
            P_RED1:   return pend ? P_WALK : P_SIDE_G;
            P_SIDE_G: return P_SIDE_Y;
            P_SIDE_Y: return P_RED2;
            P_WALK:   return P_RED2;
            default:  return P_MAIN_G;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock cycle: check per-cycle outputs against the model, then drive inputs.
    task automatic cycle(input bit wr, input bit ss, input bit te);
        exp_t   e;
        phase_e nx;
        bit     eff;
        bit     load_next;
        @(negedge clock);
        if (m_load_now) m_since = 0;
        else if (m_since >= 0) m_since++;
        check("count_en", count_en, (!m_load_now && m_since > 0 && (m_since % TD) == 0));
        check("load_timing", load, m_load_now);
        e = expect_for(m_phase);
        check("main_hold", main_light, e.m);
        check("side_hold", side_light, e.s);
        check("walk_hold", walk_light, e.w);

        if (m_fresh) te = 1'b0;
        walk_req      = wr;
        side_sensor   = ss;
        timer_expired = te;

        load_next = m_fresh;
        eff       = te && !m_load_now;
        nx        = m_phase;
        if (m_fresh) sb_q.push_back(expect_for(P_MAIN_G));
        if (eff) begin
            nx = next_of(m_phase, ss || m_pend || wr, m_pend);
            sb_q.push_back(expect_for(nx));
            load_next = 1'b1;
        end
        if (eff && nx == P_WALK) m_pend = wr;
        else                     m_pend = m_pend || wr;
        m_phase    = nx;
        m_load_now = load_next;
        m_fresh    = 1'b0;
    endtask

    task automatic expire(input bit wr, input bit ss);
        cycle(wr, ss, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
    endtask

    // Asserts reset asynchronously mid-cycle, holds it 5 cycles, releases before edge 1.
    task automatic do_reset();
        @(posedge clock);
        #2;
        reset         = 1'b0;
        walk_req      = 1'b0;
        side_sensor   = 1'b0;
        timer_expired = 1'b0;
        #1;
        check("rst_main", main_light, 3'b001);
        check("rst_side", side_light, 3'b100);
        check("rst_walk", walk_light, 1'b0);
        check("rst_load", load, 1'b0);
        check("rst_count_en", count_en, 1'b0);
        check("rst_load_value", load_value, 9'd20);
        repeat (5) @(posedge clock);
        #2;
        reset      = 1'b1;
        sb_q.delete();
        m_phase    = P_MAIN_G;
        m_pend     = 1'b0;
        m_load_now = 1'b0;
        m_fresh    = 1'b1;
        m_since    = -1;
    endtask

    // Scoreboard monitor: every load pulse must match the oldest expected phase entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset && load) begin
                check("load_expected", (sb_q.size() > 0), 1'b1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("sb_load_value", load_value, e.d);
                    check("sb_main", main_light, e.m);
                    check("sb_side", side_light, e.s);
                    check("sb_walk", walk_light, e.w);
                    check("sb_no_tick_on_load", count_en, 1'b0);
                end
            end
        end
    end

    initial begin
        do_reset();
        repeat (8) cycle(1'b0, 1'b0, 1'b0);

        repeat (3) expire(1'b0, 1'b0);

        expire(1'b0, 1'b1);
        expire(1'b0, 1'b0);
        expire(1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        repeat (7) expire(1'b0, 1'b0);
        expire(1'b0, 1'b0);

        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        do_reset();
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        expire(1'b0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 799) == 0) do_reset();
            cycle($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
        end

        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
